// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg: shared state encoding and PC-source select codes for fetch_control
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    ST_WARMUP = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_HALT   = 3'd3
  } fetch_state_e;

  localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
  localparam logic [1:0]  PC_SEL_BR  = 2'b01;
  localparam logic [1:0]  PC_SEL_JMP = 2'b10;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_control_if.sv
// ============================================================================
// fetch_control_if: request inputs (decode/EX) and fetch-datapath control outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_control_if #(
  parameter int PC_W  = 11,
  parameter int CNT_W = 16
);

  logic            stall_req;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump_req;
  logic [PC_W-1:0] jump_target;
  logic            halt_det;
  logic            resume;
  logic            step;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic [1:0]       pc_sel;
  logic [PC_W-1:0]  redirect_pc;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] stall_count;
  logic             wdog_err;

  // Requester side (decode / EX / debug)
  modport master (
    output stall_req, branch_taken, branch_target, jump_req, jump_target,
           halt_det, resume, step,
    input  pc_we, ifid_we, ifid_flush, pc_sel, redirect_pc, state_o,
           stall_count, wdog_err
  );

  // Sequencer side
  modport slave (
    input  stall_req, branch_taken, branch_target, jump_req, jump_target,
           halt_det, resume, step,
    output pc_we, ifid_we, ifid_flush, pc_sel, redirect_pc, state_o,
           stall_count, wdog_err
  );

endinterface

`default_nettype wire

// File: rtl/stall_watchdog.sv
// ============================================================================
// stall_watchdog: consecutive-stall run length, saturating total, sticky trip flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module stall_watchdog #(
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall_cycle,
  output logic             at_limit,
  output logic [CNT_W-1:0] stall_count,
  output logic             wdog_err
);

  localparam int              RUN_W     = $clog2(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_TIMEOUT - 1);

  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             wdog_err_q, wdog_err_d;

  // at_limit depends on state only, so the parent can combine it with its
  // own stall decision without a combinational loop through this block.
  assign at_limit = (run_len_q == RUN_LIMIT);

  always_comb begin
    run_len_d     = '0;
    stall_count_d = stall_count_q;
    wdog_err_d    = wdog_err_q;
    if (stall_cycle) begin
      if (!at_limit) begin
        run_len_d = run_len_q + 1'b1;
      end
      if (stall_count_q != '1) begin
        stall_count_d = stall_count_q + 1'b1;
      end
      if (at_limit) begin
        wdog_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_len_q     <= '0;
      stall_count_q <= '0;
      wdog_err_q    <= 1'b0;
    end else begin
      run_len_q     <= run_len_d;
      stall_count_q <= stall_count_d;
      wdog_err_q    <= wdog_err_d;
    end
  end

  assign stall_count = stall_count_q;
  assign wdog_err    = wdog_err_q;

endmodule

`default_nettype wire

// File: rtl/fetch_control.sv
// ============================================================================
// fetch_control: instruction-fetch sequencer (warm-up, redirect/flush, stall, halt)
// Optional: FETCH_STEP_EN enables single-step fetch while halted.  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_control
  import fetch_pkg::*;
#(
  parameter int PC_W          = 11,
  parameter int WARMUP_CYCLES = 2,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  fetch_control_if.slave bus
);

  localparam int WARM_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

  logic            pc_we, ifid_we, ifid_flush, stall_cycle, at_limit;
  logic [1:0]      pc_sel;
  logic [PC_W-1:0] redirect_pc;

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    redirect_pc = '0;
    stall_cycle = 1'b0;

    unique case (state_q)
      ST_WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.branch_taken || bus.jump_req) begin
          // The redirect cycle itself is the first flush cycle.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          pc_sel      = bus.branch_taken ? PC_SEL_BR : PC_SEL_JMP;
          redirect_pc = bus.branch_taken ? bus.branch_target : bus.jump_target;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_W'(1);
          end
        end else if (bus.stall_req) begin
          ifid_flush  = 1'b0;
          stall_cycle = 1'b1;
          if (at_limit) begin
            state_d = ST_HALT;
          end
        end else if (bus.halt_det) begin
          ifid_we = 1'b1;
          state_d = ST_HALT;
        end else begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b0;
        end
      end

      ST_FLUSH: begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        if (bus.branch_taken) begin
          pc_sel      = PC_SEL_BR;
          redirect_pc = bus.branch_target;
          flush_cnt_d = FLUSH_W'(1);
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_RUN;
`ifdef FETCH_STEP_EN
        end else if (bus.step) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b0;
`endif
        end
      end

      default: state_d = ST_WARMUP;
    endcase
  end

`ifndef FETCH_STEP_EN
  logic step_unused;
  assign step_unused = bus.step;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WARMUP;
      warm_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_stall_watchdog (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall_cycle (stall_cycle),
    .at_limit    (at_limit),
    .stall_count (bus.stall_count),
    .wdog_err    (bus.wdog_err)
  );

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.pc_sel      = pc_sel;
  assign bus.redirect_pc = redirect_pc;
  assign bus.state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_control.sv
// ============================================================================
// tb_fetch_control: table-driven check of fetch_control (default and 3-cycle flush builds)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_control;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 clock = ~clock;

  fetch_control_if #(.PC_W(11), .CNT_W(16)) bus0 ();
  fetch_control_if #(.PC_W(11), .CNT_W(4))  bus1 ();

  fetch_control #(
    .PC_W(11), .WARMUP_CYCLES(2), .FLUSH_CYCLES(1), .STALL_TIMEOUT(64), .CNT_W(16)
  ) dut0 (
    .clock   (clock),
    .reset_n (rst0_n),
    .bus     (bus0)
  );

  fetch_control #(
    .PC_W(11), .WARMUP_CYCLES(2), .FLUSH_CYCLES(3), .STALL_TIMEOUT(64), .CNT_W(4)
  ) dut1 (
    .clock   (clock),
    .reset_n (rst1_n),
    .bus     (bus1)
  );

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [10:0] brt;
    logic        jmp;
    logic [10:0] jt;
    logic        halt;
    logic        res;
    logic        step;
  } ins_t;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic [1:0]  pc_sel;
    logic [10:0] rpc;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic        wdog;
  } outs_t;

  typedef struct {
    string name;
    bit    unit;
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic ins_t mk_in(logic stall, logic br, logic [10:0] brt, logic jmp,
                                 logic [10:0] jt, logic halt, logic res, logic step);
    ins_t r;
    r = '{stall, br, brt, jmp, jt, halt, res, step};
    return r;
  endfunction

  function automatic outs_t mk_out(logic we, logic ifwe, logic fl, logic [1:0] sel,
                                   logic [10:0] rpc, logic [2:0] st, logic [15:0] cnt,
                                   logic wd);
    outs_t r;
    r = '{we, ifwe, fl, sel, rpc, st, cnt, wd};
    return r;
  endfunction

  function automatic outs_t fetch_o(logic [2:0] st, logic [15:0] cnt, logic wd);
    return mk_out(1'b1, 1'b1, 1'b0, PC_SEL_SEQ, 11'h0, st, cnt, wd);
  endfunction

  function automatic outs_t stall_o(logic [15:0] cnt);
    return mk_out(1'b0, 1'b0, 1'b0, PC_SEL_SEQ, 11'h0, ST_RUN, cnt, 1'b0);
  endfunction

  function automatic outs_t halt_o(logic [15:0] cnt, logic wd);
    return mk_out(1'b0, 1'b0, 1'b1, PC_SEL_SEQ, 11'h0, ST_HALT, cnt, wd);
  endfunction

  function automatic outs_t warm_o();
    return mk_out(1'b0, 1'b0, 1'b1, PC_SEL_SEQ, 11'h0, ST_WARMUP, 16'd0, 1'b0);
  endfunction

  task automatic add(string name, bit u, ins_t in, outs_t exp);
    vec_t v;
    v.name = name;
    v.unit = u;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(bit u, ins_t in);
    if (!u) begin
      bus0.stall_req = in.stall;  bus0.branch_taken = in.br;  bus0.branch_target = in.brt;
      bus0.jump_req  = in.jmp;    bus0.jump_target  = in.jt;  bus0.halt_det      = in.halt;
      bus0.resume    = in.res;    bus0.step         = in.step;
    end else begin
      bus1.stall_req = in.stall;  bus1.branch_taken = in.br;  bus1.branch_target = in.brt;
      bus1.jump_req  = in.jmp;    bus1.jump_target  = in.jt;  bus1.halt_det      = in.halt;
      bus1.resume    = in.res;    bus1.step         = in.step;
    end
  endtask

  function automatic outs_t sample(bit u);
    outs_t r;
    if (!u) begin
      r = '{bus0.pc_we, bus0.ifid_we, bus0.ifid_flush, bus0.pc_sel, bus0.redirect_pc,
            bus0.state_o, bus0.stall_count, bus0.wdog_err};
    end else begin
      r = '{bus1.pc_we, bus1.ifid_we, bus1.ifid_flush, bus1.pc_sel, bus1.redirect_pc,
            bus1.state_o, {12'h000, bus1.stall_count}, bus1.wdog_err};
    end
    return r;
  endfunction

  task automatic check(string name, bit u, outs_t exp);
    outs_t a;
    a = sample(u);
    n_tests++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s (unit %0d): got we=%b ifwe=%b fl=%b sel=%b rpc=%h st=%0d cnt=%0d wd=%b, expected we=%b ifwe=%b fl=%b sel=%b rpc=%h st=%0d cnt=%0d wd=%b",
               name, u, a.pc_we, a.ifid_we, a.ifid_flush, a.pc_sel, a.rpc, a.st, a.cnt, a.wdog,
               exp.pc_we, exp.ifid_we, exp.ifid_flush, exp.pc_sel, exp.rpc, exp.st, exp.cnt, exp.wdog);
    end
  endtask

  // Entered and left at posedge+1; outputs compared at the following negedge.
  task automatic run_vecs();
    vec_t v, e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      drive(v.unit, v.in);
      sb.push_back(v);
      @(negedge clock);
      e = sb.pop_front();
      check(e.name, e.unit, e.exp);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ins_t idle, stall, resume;
    idle   = '0;
    stall  = mk_in(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0);
    resume = mk_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b1, 1'b0);

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    drive(1'b0, mk_in(1'b1, 1'b1, 11'h040, 1'b1, 11'h020, 1'b0, 1'b0, 1'b0));
    drive(1'b1, idle);
    repeat (3) @(negedge clock);
    check("reset_u0", 1'b0, warm_o());
    check("reset_u1", 1'b1, warm_o());

    // ---------------- unit 0: default build ----------------
    @(posedge clock); #1;
    rst0_n = 1'b1;
    add("warmup_c0", 0, idle, warm_o());
    add("warmup_ignores_req", 0, mk_in(1'b1, 1'b1, 11'h040, 1'b1, 11'h020, 1'b1, 1'b0, 1'b0), warm_o());
    add("run_first", 0, idle, fetch_o(ST_RUN, 16'd0, 1'b0));
    add("run_seq", 0, idle, fetch_o(ST_RUN, 16'd0, 1'b0));
    add("branch_040", 0, mk_in(1'b0, 1'b1, 11'h040, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_BR, 11'h040, ST_RUN, 16'd0, 1'b0));
    add("after_branch", 0, idle, fetch_o(ST_RUN, 16'd0, 1'b0));
    add("br_jmp_stall", 0, mk_in(1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_BR, 11'h010, ST_RUN, 16'd0, 1'b0));
    add("jump_020", 0, mk_in(1'b0, 1'b0, 11'h0, 1'b1, 11'h020, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_JMP, 11'h020, ST_RUN, 16'd0, 1'b0));
    add("jump_7ff_stall", 0, mk_in(1'b1, 1'b0, 11'h0, 1'b1, 11'h7FF, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_JMP, 11'h7FF, ST_RUN, 16'd0, 1'b0));
    for (int i = 0; i < 3; i++) add("stall3", 0, stall, stall_o(16'(i)));
    add("stall3_done", 0, idle, fetch_o(ST_RUN, 16'd3, 1'b0));
    add("stall_over_halt", 0, mk_in(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0, 1'b0), stall_o(16'd3));
    add("halt_det", 0, mk_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0, 1'b0),
        mk_out(1'b0, 1'b1, 1'b1, PC_SEL_SEQ, 11'h0, ST_RUN, 16'd4, 1'b0));
    add("halted", 0, idle, halt_o(16'd4, 1'b0));
    add("halt_ignores_req", 0, mk_in(1'b1, 1'b1, 11'h111, 1'b1, 11'h222, 1'b1, 1'b0, 1'b0), halt_o(16'd4, 1'b0));
`ifdef FETCH_STEP_EN
    add("step_fetch", 0, mk_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b1), fetch_o(ST_HALT, 16'd4, 1'b0));
`else
    add("step_ignored", 0, mk_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b1), halt_o(16'd4, 1'b0));
`endif
    add("halt_after_step", 0, idle, halt_o(16'd4, 1'b0));
    add("resume_over_step", 0, mk_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b1, 1'b1), halt_o(16'd4, 1'b0));
    add("resumed", 0, idle, fetch_o(ST_RUN, 16'd4, 1'b0));
    for (int i = 0; i < 63; i++) add("stall63", 0, stall, stall_o(16'(4 + i)));
    add("stall63_break", 0, idle, fetch_o(ST_RUN, 16'd67, 1'b0));
    for (int i = 0; i < 64; i++) add("stall64", 0, stall, stall_o(16'(67 + i)));
    add("wdog_halt", 0, stall, halt_o(16'd131, 1'b1));
    add("wdog_resume", 0, resume, halt_o(16'd131, 1'b1));
    add("wdog_sticky", 0, idle, fetch_o(ST_RUN, 16'd131, 1'b1));
    run_vecs();

    // ---------------- unit 1: 3-cycle flush, 4-bit stall counter ----------------
    drive(1'b0, idle);
    rst1_n = 1'b1;
    add("u1_warmup_c0", 1, idle, warm_o());
    add("u1_warmup_c1", 1, idle, warm_o());
    add("u1_branch_100", 1, mk_in(1'b0, 1'b1, 11'h100, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_BR, 11'h100, ST_RUN, 16'd0, 1'b0));
    add("u1_flush_ignores", 1, mk_in(1'b1, 1'b0, 11'h0, 1'b1, 11'h200, 1'b1, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_SEQ, 11'h0, ST_FLUSH, 16'd0, 1'b0));
    add("u1_flush_rebranch", 1, mk_in(1'b0, 1'b1, 11'h055, 1'b1, 11'h200, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_BR, 11'h055, ST_FLUSH, 16'd0, 1'b0));
    add("u1_flush_c2", 1, idle, mk_out(1'b1, 1'b1, 1'b1, PC_SEL_SEQ, 11'h0, ST_FLUSH, 16'd0, 1'b0));
    add("u1_flush_c3", 1, idle, mk_out(1'b1, 1'b1, 1'b1, PC_SEL_SEQ, 11'h0, ST_FLUSH, 16'd0, 1'b0));
    add("u1_run", 1, idle, fetch_o(ST_RUN, 16'd0, 1'b0));
    for (int i = 0; i < 20; i++) add("u1_stall_sat", 1, stall, stall_o(16'((i < 15) ? i : 15)));
    add("u1_sat_hold", 1, idle, fetch_o(ST_RUN, 16'd15, 1'b0));
    add("u1_branch_033", 1, mk_in(1'b0, 1'b1, 11'h033, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0),
        mk_out(1'b1, 1'b1, 1'b1, PC_SEL_BR, 11'h033, ST_RUN, 16'd15, 1'b0));
    add("u1_in_flush", 1, idle, mk_out(1'b1, 1'b1, 1'b1, PC_SEL_SEQ, 11'h0, ST_FLUSH, 16'd15, 1'b0));
    run_vecs();

    // Asynchronous reset while still in FLUSH, between clock edges
    #2;
    rst1_n = 1'b0;
    #1;
    check("u1_async_rst_mid_flush", 1'b1, warm_o());
    @(negedge clock);
    check("u1_rst_hold", 1'b1, warm_o());
    @(posedge clock); #1;
    rst1_n = 1'b1;
    add("u1_rewarm_c0", 1, idle, warm_o());
    add("u1_rewarm_c1", 1, idle, warm_o());
    add("u1_rerun", 1, idle, fetch_o(ST_RUN, 16'd0, 1'b0));
    run_vecs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
